// File: rtl/led_pkg.sv
// Shared definitions for the LED/switch front end: debounce FSM encoding and window lengths.
package led_pkg;

    // Per-channel debounce state
    typedef enum logic {
        ST_STABLE  = 1'b0,
        ST_PENDING = 1'b1
    } db_state_e;

    // 10 ms at 125 MHz
    localparam int unsigned DEBOUNCE_125M_10MS = 1250000;
    // Short window so simulations finish quickly
    localparam int unsigned DEBOUNCE_SIM       = 4;

endpackage

// File: rtl/sw_debounce_ch.sv
// One switch channel: 2-FF synchroniser, stability FSM with counter, registered level and strobes.
module sw_debounce_ch
    import led_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYC = DEBOUNCE_125M_10MS
) (
    input  logic clk,
    input  logic rst,
    input  logic sw_in,
    output logic sw_db,
    output logic sw_rise,
    output logic sw_fall,
    output logic pending_nxt
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYC);
    // Count value on the edge that accepts the new level
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

    logic             s1;
    logic             s2;
    db_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             db_q, db_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;

    // Bring the asynchronous pin into clk; only s2 is used past this point
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= sw_in;
            s2 <= s1;
        end
    end

    // FSM state, stability counter, accepted level and edge strobes
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_STABLE;
            cnt_q   <= '0;
            db_q    <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            db_q    <= db_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    // Next state: count consecutive cycles where s2 disagrees with the accepted level
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        db_d    = db_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        unique case (state_q)
            ST_STABLE: begin
                if (s2 != db_q) begin
                    state_d = ST_PENDING;
                    cnt_d   = CNT_W'(1);
                end else begin
                    cnt_d   = '0;
                end
            end
            ST_PENDING: begin
                if (s2 == db_q) begin
                    // Glitch: drop the partial window silently
                    state_d = ST_STABLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_STABLE;
                    cnt_d   = '0;
                    db_d    = s2;
                    rise_d  = s2;
                    fall_d  = ~s2;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_STABLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs come straight from registers; pending_nxt lets the top register busy in step
    always_comb begin
        sw_db       = db_q;
        sw_rise     = rise_q;
        sw_fall     = fall_q;
        pending_nxt = (state_d == ST_PENDING);
    end

endmodule

// File: rtl/sw_debounce.sv
// Slide-switch conditioning: N_CH independent debounce channels plus an aggregate busy flag.
module sw_debounce
    import led_pkg::*;
#(
    parameter int unsigned N_CH         = 4,
    parameter int unsigned DEBOUNCE_CYC = DEBOUNCE_125M_10MS
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] sw_in,
    output logic [N_CH-1:0] sw_db,
    output logic [N_CH-1:0] sw_rise,
    output logic [N_CH-1:0] sw_fall,
    output logic            busy
);

    logic [N_CH-1:0] pending_nxt;
    logic            busy_q;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        sw_debounce_ch #(
            .DEBOUNCE_CYC(DEBOUNCE_CYC)
        ) u_ch (
            .clk        (clk),
            .rst        (rst),
            .sw_in      (sw_in[i]),
            .sw_db      (sw_db[i]),
            .sw_rise    (sw_rise[i]),
            .sw_fall    (sw_fall[i]),
            .pending_nxt(pending_nxt[i])
        );
    end

    // Registered OR of pending channels, aligned with the channel state registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_q <= 1'b0;
        end else begin
            busy_q <= |pending_nxt;
        end
    end

    assign busy = busy_q;

endmodule

// File: tb/tb_sw_debounce.sv
// Directed bench for sw_debounce with a 4-cycle window and 4 channels.
module tb_sw_debounce;

    logic       clk;
    logic       rst;
    logic [3:0] sw_in;
    logic [3:0] sw_db;
    logic [3:0] sw_rise;
    logic [3:0] sw_fall;
    logic       busy;

    int checks;
    int errors;

    sw_debounce #(
        .N_CH        (4),
        .DEBOUNCE_CYC(4)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .sw_in  (sw_in),
        .sw_db  (sw_db),
        .sw_rise(sw_rise),
        .sw_fall(sw_fall),
        .busy   (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] sw;
        logic [3:0] db;
        logic [3:0] rise;
        logic [3:0] fall;
        logic       bsy;
    } vec_t;

    vec_t vecs[21];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    initial begin
        int         n_rise;
        int         n_fall;
        logic       seen_bad;
        logic       seen_busy;
        checks = 0;
        errors = 0;

        // After the input is set just past an edge, that next edge is k. Row j is sampled
        // just past edge k+j; acceptance lands on edge k+5, pending spans edges k+2..k+4.
        vecs[0]  = '{4'hF, 4'h0, 4'h0, 4'h0, 1'b0};
        vecs[1]  = '{4'hF, 4'h0, 4'h0, 4'h0, 1'b0};
        vecs[2]  = '{4'hF, 4'h0, 4'h0, 4'h0, 1'b1};
        vecs[3]  = '{4'hF, 4'h0, 4'h0, 4'h0, 1'b1};
        vecs[4]  = '{4'hF, 4'h0, 4'h0, 4'h0, 1'b1};
        vecs[5]  = '{4'hF, 4'hF, 4'hF, 4'h0, 1'b0};
        vecs[6]  = '{4'hF, 4'hF, 4'h0, 4'h0, 1'b0};
        vecs[7]  = '{4'h0, 4'hF, 4'h0, 4'h0, 1'b0};
        vecs[8]  = '{4'h0, 4'hF, 4'h0, 4'h0, 1'b0};
        vecs[9]  = '{4'h0, 4'hF, 4'h0, 4'h0, 1'b1};
        vecs[10] = '{4'h0, 4'hF, 4'h0, 4'h0, 1'b1};
        vecs[11] = '{4'h0, 4'hF, 4'h0, 4'h0, 1'b1};
        vecs[12] = '{4'h0, 4'h0, 4'h0, 4'hF, 1'b0};
        vecs[13] = '{4'h0, 4'h0, 4'h0, 4'h0, 1'b0};
        vecs[14] = '{4'h1, 4'h0, 4'h0, 4'h0, 1'b0};
        vecs[15] = '{4'h1, 4'h0, 4'h0, 4'h0, 1'b0};
        vecs[16] = '{4'h1, 4'h0, 4'h0, 4'h0, 1'b1};
        vecs[17] = '{4'h1, 4'h0, 4'h0, 4'h0, 1'b1};
        vecs[18] = '{4'h1, 4'h0, 4'h0, 4'h0, 1'b1};
        vecs[19] = '{4'h1, 4'h1, 4'h1, 4'h0, 1'b0};
        vecs[20] = '{4'h1, 4'h1, 4'h0, 4'h0, 1'b0};

        // Reset held with all pins high
        rst   = 1'b0;
        sw_in = 4'hF;
        repeat (4) tick();
        check("reset_db", sw_db, 4'h0);
        check("reset_rise", sw_rise, 4'h0);
        check("reset_fall", sw_fall, 4'h0);
        check("reset_busy", {3'b0, busy}, 4'h0);
        rst = 1'b1;

        // Table: post-reset acceptance, release of all, clean press on ch0
        for (int i = 0; i < 21; i++) begin
            sw_in = vecs[i].sw;
            tick();
            check($sformatf("vec%0d_db", i), sw_db, vecs[i].db);
            check($sformatf("vec%0d_rise", i), sw_rise, vecs[i].rise);
            check($sformatf("vec%0d_fall", i), sw_fall, vecs[i].fall);
            check($sformatf("vec%0d_busy", i), {3'b0, busy}, {3'b0, vecs[i].bsy});
        end

        // Glitch on ch1: three cycles high is one short of the window
        seen_bad  = 1'b0;
        seen_busy = 1'b0;
        sw_in = 4'h3;
        repeat (3) begin
            tick();
            if (sw_db[1] || sw_rise[1] || sw_fall[1]) seen_bad = 1'b1;
            if (busy) seen_busy = 1'b1;
        end
        sw_in = 4'h1;
        repeat (10) begin
            tick();
            if (sw_db[1] || sw_rise[1] || sw_fall[1]) seen_bad = 1'b1;
            if (busy) seen_busy = 1'b1;
        end
        check("glitch_no_change", {3'b0, seen_bad}, 4'h0);
        check("glitch_busy_seen", {3'b0, seen_busy}, 4'h1);
        check("glitch_busy_end", {3'b0, busy}, 4'h0);
        check("glitch_db", sw_db, 4'h1);

        // Bounce on ch2: 2-cycle segments 1,0,1,0 then settle high
        n_rise = 0;
        for (int i = 0; i < 4; i++) begin
            sw_in = (i % 2 == 0) ? 4'h5 : 4'h1;
            repeat (2) begin
                tick();
                if (sw_rise[2]) n_rise++;
            end
        end
        sw_in = 4'h5;
        repeat (5) begin
            tick();
            if (sw_rise[2]) n_rise++;
        end
        check("bounce_db_before", sw_db, 4'h1);
        tick();
        if (sw_rise[2]) n_rise++;
        check("bounce_db_accept", sw_db, 4'h5);
        check("bounce_rise_accept", sw_rise, 4'h4);
        repeat (6) begin
            tick();
            if (sw_rise[2]) n_rise++;
        end
        check("bounce_rise_count", 4'(n_rise), 4'h1);

        // Release on ch3: first bring it high, then drop it
        sw_in = 4'hD;
        repeat (8) tick();
        check("release_setup_db", sw_db, 4'hD);
        sw_in    = 4'h5;
        n_fall   = 0;
        seen_bad = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            tick();
            if (sw_fall[3]) n_fall++;
            if ((sw_db & 4'h7) != 4'h5 || (sw_rise | (sw_fall & 4'h7)) != 4'h0) seen_bad = 1'b1;
            if (i == 5) check("release_db_before", sw_db, 4'hD);
            if (i == 6) begin
                check("release_db_accept", sw_db, 4'h5);
                check("release_fall", sw_fall, 4'h8);
            end
        end
        check("release_fall_count", 4'(n_fall), 4'h1);
        check("release_others", {3'b0, seen_bad}, 4'h0);

        // Reset while ch1 is two cycles into its window
        sw_in = 4'h7;
        repeat (4) tick();
        check("midrst_busy_before", {3'b0, busy}, 4'h1);
        rst = 1'b0;
        #1;
        check("midrst_db", sw_db, 4'h0);
        check("midrst_rise", sw_rise, 4'h0);
        check("midrst_fall", sw_fall, 4'h0);
        check("midrst_busy", {3'b0, busy}, 4'h0);
        repeat (3) tick();
        rst = 1'b1;
        repeat (3) tick();
        check("postrst_busy", {3'b0, busy}, 4'h1);
        repeat (2) tick();
        check("postrst_db_before", sw_db, 4'h0);
        tick();
        check("postrst_db_accept", sw_db, 4'h7);
        check("postrst_rise", sw_rise, 4'h7);
        check("postrst_busy_end", {3'b0, busy}, 4'h0);
        tick();
        check("postrst_rise_clear", sw_rise, 4'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
